jelly_fifo_write_arbiter: RTL
=============================

// Module: jelly_fifo_write_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter that merges NUM requester streams into the single
//  write port of a FIFO, such as the s_* side of jelly_fifo_async_fwtf.
//  A grant is held from a packet's first beat until its last beat, so packets never interleave.
//  A new packet starts only when the FIFO reports at least FREE_THRESH free entries.
//  The output stage is a single register.
// PARAMETERS
//  NUM          4   number of requester channels (>=1)
//  DATA_WIDTH   16  payload width per beat
//  ID_WIDTH     2   width of channel index (>=1, 2**ID_WIDTH >= NUM)
//  FREE_WIDTH   3   width of free_count (FIFO PTR_WIDTH+1)
//  FREE_THRESH  0   minimum free_count to start a packet; 0 disables the check
// PORTS
//  clk         in   1               single clock, rising edge
//  reset_n     in   1               asynchronous, active-low reset
//  s_data      in   NUM*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//  s_last      in   NUM             last beat of packet, per channel
//  s_valid     in   NUM             beat valid, per channel
//  s_ready     out  NUM             beat accepted, per channel
//  m_data      out  DATA_WIDTH      to FIFO s_data
//  m_id        out  ID_WIDTH        source channel of m_data
//  m_last      out  1               last beat of packet
//  m_valid     out  1               to FIFO s_valid
//  m_ready     in   1               from FIFO s_ready
//  free_count  in   FREE_WIDTH      from FIFO s_free_count
//  busy        out  1               1 while a grant is held (state BUSY)
//  grant_id    out  ID_WIDTH        currently or last granted channel
// BEHAVIOUR
//  - Reset (reset_n=0, async): m_valid=0, m_last=0, m_data=0, m_id=0, busy=0,
//    grant_id=NUM-1, s_ready=0, state IDLE. The first search after reset starts at channel 0.
//  - A transfer on any port occurs when valid && ready are high at a clk edge.
//  - Output register: out_en = !m_valid || m_ready.
//  - IDLE: s_ready=0 on all channels.
//    If any s_valid=1 and (FREE_THRESH==0 || free_count>=FREE_THRESH):
//    grant_id <= the first channel with s_valid=1, searching from (grant_id+1) mod NUM
//    upward with wrap-around; state <= BUSY.
//  - BUSY: s_ready[grant_id]=out_en; all other s_ready=0.
//    On a transfer from channel g: m_data<=s_data[g], m_last<=s_last[g], m_id<=g, m_valid<=1.
//  - If m_ready=1 and no input transfer occurs in that cycle: m_valid<=0.
//  - While m_valid && !m_ready: m_data, m_id and m_last are held stable.
//  - A transfer with s_last=1 sends state to IDLE. grant_id is kept and serves as the
//    round-robin pointer. This costs one decision cycle between packets, so the input side
//    carries at most one packet every 2 cycles for 1-beat packets.
//  - Latency: one clk from input acceptance to m_valid.
//  - free_count is sampled only in IDLE. Mid-packet, backpressure comes only from m_ready.
//  - If the granted channel drops s_valid mid-packet, the grant is held indefinitely.
//    There is no timeout.
//  - NUM=1: channel 0 is always selected; the IDLE/BUSY sequencing is unchanged.
//  - Reset asserted mid-packet: outputs clear immediately and the partial packet is
//    discarded. Requesters must also be reset.
// TESTING
//  1 NUM=4, all s_valid=1, 1-beat packets, m_ready=1
//    -> m_id=0,1,2,3,0,... with one packet every 2 cycles.
//  2 ch1 sends a 3-beat packet (data A,B,C) while ch2 is requesting
//    -> m_data A,B,C with m_id=1 contiguous and m_last on C, then ch2's packet.
//  3 m_ready=0 for 5 cycles mid-packet
//    -> m_data is stable, s_ready[g]=0, no beat is lost or duplicated after release.
//  4 FREE_THRESH=2, free_count=1 with ch0 valid
//    -> busy stays 0; set free_count=2 -> busy=1 on the next edge.
//  5 reset_n=0 mid-packet
//    -> m_valid=0 and s_ready=0 without waiting for clk; after release the first grant is ch0.
//  6 10k cycles of random s_valid/m_ready with per-channel sequence numbers
//    -> per-channel order is preserved, no interleaving inside a packet,
//       and the count of m_last equals the packets sent.

Source files
------------

// File: rtl/jelly_fifo_write_arbiter.sv
// jelly_fifo_write_arbiter
// Packet-aware round-robin arbiter that merges NUM requester streams into the
// single write port of a FIFO. A grant is held from a packet's first beat to
// its last beat, and a new packet starts only when the FIFO has room for it.
module jelly_fifo_write_arbiter #(
  parameter int NUM         = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = 2,
  parameter int FREE_WIDTH  = 3,
  parameter int FREE_THRESH = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM*DATA_WIDTH-1:0] s_data,
  input  logic [NUM-1:0]            s_last,
  input  logic [NUM-1:0]            s_valid,
  output logic [NUM-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [ID_WIDTH-1:0]       m_id,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  input  logic [FREE_WIDTH-1:0]     free_count,
  output logic                      busy,
  output logic [ID_WIDTH-1:0]       grant_id
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ID_WIDTH-1:0]   r_m_id;
  logic                  r_m_last;
  logic                  r_m_valid;

  logic                  w_out_en;
  logic                  w_free_ok;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_xfer;
  logic [ID_WIDTH-1:0]   w_next_grant;

  // The output register can take a new beat when empty or being drained.
  assign w_out_en = !r_m_valid || m_ready;

  // Free-space gate for starting a packet; a zero threshold disables it.
  if (FREE_THRESH == 0) begin : g_no_thresh
    logic w_unused_free;
    assign w_unused_free = ^free_count;
    assign w_free_ok     = 1'b1;
  end else begin : g_thresh
    assign w_free_ok = (free_count >= FREE_WIDTH'(FREE_THRESH));
  end

  // Select the granted channel's beat and drive its ready while a grant is held.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    s_ready   = '0;
    for (int j = 0; j < NUM; j++) begin
      if (int'(r_grant_id) == j) begin
        w_g_valid  = s_valid[j];
        w_g_last   = s_last[j];
        w_g_data   = s_data[j*DATA_WIDTH +: DATA_WIDTH];
        s_ready[j] = (r_state == ST_BUSY) && w_out_en;
      end
    end
  end

  assign w_xfer = (r_state == ST_BUSY) && w_out_en && w_g_valid;

  // Round-robin search: first valid channel above the pointer, else wrap to the lowest.
  always_comb begin
    logic                found_hi;
    logic                found_lo;
    logic [ID_WIDTH-1:0] idx_hi;
    logic [ID_WIDTH-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = 0; j < NUM; j++) begin
      if (!found_hi && s_valid[j] && (j > int'(r_grant_id))) begin
        found_hi = 1'b1;
        idx_hi   = ID_WIDTH'(j);
      end
      if (!found_lo && s_valid[j] && (j <= int'(r_grant_id))) begin
        found_lo = 1'b1;
        idx_lo   = ID_WIDTH'(j);
      end
    end
    w_next_grant = found_hi ? idx_hi : idx_lo;
  end

  // Grant FSM: decide in IDLE, hold the grant in BUSY until the last beat is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_grant_id <= ID_WIDTH'(NUM - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((|s_valid) && w_free_ok) begin
            r_grant_id <= w_next_grant;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_xfer && w_g_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Single output register; contents held while the FIFO stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data  <= '0;
      r_m_id    <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_xfer) begin
      r_m_data  <= w_g_data;
      r_m_id    <= r_grant_id;
      r_m_last  <= w_g_last;
      r_m_valid <= 1'b1;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data   = r_m_data;
  assign m_id     = r_m_id;
  assign m_last   = r_m_last;
  assign m_valid  = r_m_valid;
  assign busy     = (r_state == ST_BUSY);
  assign grant_id = r_grant_id;

endmodule
